// File: rtl/breath_led_array_pkg.sv
// Shared constants and helpers for the multi-channel breathing LED controller.
// Mode encodings, triangle-wave mapping and per-channel phase offsets.
// Functions are elaboration/combinational helpers only; no state lives here.
package breath_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_STEADY  = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_BLINK   = 2'd3;

  // Fold a (bits+1)-wide phase into a 0..MAX..0 ramp: the top bit selects
  // the falling half, which is the bitwise complement of the low bits.
  function automatic logic [31:0] tri_wave(input logic [31:0] x, input int bits);
    logic [31:0] mask;
    mask = (32'd1 << bits) - 32'd1;
    if (x[bits]) begin
      return ~x & mask;
    end
    return x & mask;
  endfunction

  // Even stagger of channel i across one full breathing period.
  function automatic logic [31:0] phase_off(input int i, input int ch, input int bits);
    int span;
    span = 1 << (bits + 1);
    return 32'((i * (span / ch)) % span);
  endfunction

endpackage

// File: rtl/breath_led_array_if.sv
// Control/status bundle between the board-level controller and the LED array.
// Purely wires; no latency of its own.
// No backpressure: LED outputs and the step pulse are free-running.
interface breath_led_array_if #(
  parameter int CH   = 4,
  parameter int BITS = 9
);
  logic            en;
  logic [1:0]      mode;
  logic [BITS-1:0] level;
  logic            phase_en;
  logic [CH-1:0]   led;
  logic            step_tick;

  modport master (output en, mode, level, phase_en, input led, step_tick);
  modport slave  (input en, mode, level, phase_en, output led, step_tick);
endinterface

// File: rtl/breath_led_array_channel.sv
// One LED channel: duty selection by mode, PWM compare and the output flop.
// One cycle from pwm/phase/mode state to led_o.
// No backpressure; en_i low blanks the output on the next edge.
module breath_channel
  import breath_pkg::*;
#(
  parameter int BITS = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [BITS-1:0] pwm_cnt_i,
  input  logic [BITS:0]   x_i,
  input  logic [1:0]      mode_i,
  input  logic [BITS-1:0] level_i,
  output logic            led_o
);

  logic [BITS-1:0] duty;
  logic            led_d;
  logic            led_q;

  // Pick the duty for this channel and decide the next pin level.
  always_comb begin
    duty  = '0;
    led_d = 1'b0;
    case (mode_i)
      MODE_STEADY: begin
        duty  = level_i;
        led_d = pwm_cnt_i < duty;
      end
      MODE_BREATHE: begin
        duty  = BITS'(tri_wave(32'(x_i), BITS));
        led_d = pwm_cnt_i < duty;
      end
      MODE_BLINK: begin
        led_d = ~x_i[BITS];
      end
      default: begin
        led_d = 1'b0;
      end
    endcase
    if (!en_i) begin
      led_d = 1'b0;
    end
  end

  // Register the pin so the output is glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/breath_led_array.sv
// CH-channel breathing LED controller sharing one PWM counter and step prescaler.
// led: 1 cycle from counter state; step_tick: 1 cycle after prescaler wrap.
// No backpressure; en low freezes all counters and blanks the LEDs.
module breath_led_array
  import breath_pkg::*;
#(
  parameter int CH    = 4,
  parameter int BITS  = 9,
  parameter int DIV   = 12_000,
  parameter int DIV_W = $clog2(DIV)
) (
  input  logic               clk,
  input  logic               rst_n,
  breath_led_array_if.slave  bus
);

  localparam logic [BITS-1:0]  MAX      = {BITS{1'b1}};
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam int               PW       = BITS + 1;

  logic [BITS-1:0]  pwm_q,   pwm_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [BITS:0]    phase_q, phase_d;
  logic [1:0]       mode_q,  mode_d;
  logic [BITS-1:0]  level_q, level_d;
  logic             tick_q,  tick_d;
  logic [CH-1:0]    led_vec;

  // Advance the counters while enabled; mode/level are only taken at the
  // last PWM cycle so every window runs with one consistent setting.
  always_comb begin
    pwm_d   = pwm_q;
    div_d   = div_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    level_d = level_q;
    tick_d  = 1'b0;
    if (bus.en) begin
      pwm_d = pwm_q + 1'b1;
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        tick_d  = 1'b1;
        phase_d = phase_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
      if (pwm_q == MAX) begin
        mode_d  = bus.mode;
        level_d = bus.level;
      end
    end
  end

  // Shared counter and configuration state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q   <= '0;
      div_q   <= '0;
      phase_q <= '0;
      mode_q  <= MODE_OFF;
      level_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      pwm_q   <= pwm_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    localparam logic [BITS:0] OFF = PW'(phase_off(i, CH, BITS));
    logic [BITS:0] x;
    // phase_en is used live so the stagger can be toggled at any time.
    assign x = phase_q + (bus.phase_en ? OFF : '0);

    breath_channel #(.BITS(BITS)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (bus.en),
      .pwm_cnt_i (pwm_q),
      .x_i       (x),
      .mode_i    (mode_q),
      .level_i   (level_q),
      .led_o     (led_vec[i])
    );
  end

  assign bus.led       = led_vec;
  assign bus.step_tick = tick_q;

endmodule

// File: tb/tb_breath_led_array.sv
// Directed bench for breath_led_array with BITS=4, DIV=3, CH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Expected values come from hand tables and closed-form cycle counts.
module tb_breath_led_array;
  import breath_pkg::*;

  localparam int CH   = 4;
  localparam int BITS = 4;
  localparam int DIV  = 3;

  localparam logic [3:0] TRI [0:31] = '{
    4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
    4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
    4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9,  4'd8,
    4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1,  4'd0
  };

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  breath_led_array_if #(.CH(CH), .BITS(BITS)) bus ();

  breath_led_array #(.CH(CH), .BITS(BITS), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;
  int hi    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s t=%0d: got 0x%0h, want 0x%0h", tag, t, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected LED vector for the cycle after state s. run2 selects the
  // post-reset BREATHE-only schedule; otherwise the STEADY/OFF/BREATHE one.
  function automatic logic [3:0] exp_led(input int s, input bit run2);
    logic [1:0] mq;
    if (s < 16)       mq = MODE_OFF;
    else if (run2)    mq = MODE_BREATHE;
    else if (s < 48)  mq = MODE_STEADY;
    else if (s < 80)  mq = MODE_OFF;
    else              mq = MODE_BREATHE;
    case (mq)
      MODE_STEADY:  return ((s % 16) < 8) ? 4'hF : 4'h0;
      MODE_BREATHE: return ((s % 16) < int'(TRI[(s / 3) % 32])) ? 4'hF : 4'h0;
      default:      return 4'h0;
    endcase
  endfunction

  function automatic logic exp_tick(input int tt);
    return (tt > 0) && (tt % 3 == 0);
  endfunction

  function automatic logic [15:0] duties();
    return {dut.g_ch[3].u_ch.duty, dut.g_ch[2].u_ch.duty,
            dut.g_ch[1].u_ch.duty, dut.g_ch[0].u_ch.duty};
  endfunction

  // Step the enabled design up to state `last`, checking every cycle.
  task automatic run_breathe(input int last);
    logic [3:0] p;
    while (t < last) begin
      cyc();
      t++;
      chk("breathe_led", 32'(bus.led), 32'(exp_led(t - 1, 1'b1)));
      chk("breathe_tick", 32'(bus.step_tick), 32'(exp_tick(t)));
      if (t >= 16 && (t % 3) == 1) begin
        p = TRI[(t / 3) % 32];
        chk("breathe_duty", 32'(duties()), 32'({p, p, p, p}));
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = MODE_OFF;
    bus.level    = '0;
    bus.phase_en = 1'b0;

    // Power-on reset.
    repeat (3) cyc();
    chk("rst_led", 32'(bus.led), 32'h0);
    chk("rst_tick", 32'(bus.step_tick), 32'h0);
    chk("rst_pwm", 32'(dut.pwm_q), 32'h0);

    // STEADY level 8, then OFF requested mid-window, then BREATHE.
    rst_n     = 1'b1;
    bus.en    = 1'b1;
    bus.mode  = MODE_STEADY;
    bus.level = 4'd8;
    for (int k = 1; k <= 81; k++) begin
      cyc();
      t = k;
      chk("run1_led", 32'(bus.led), 32'(exp_led(k - 1, 1'b0)));
      chk("run1_tick", 32'(bus.step_tick), 32'(exp_tick(k)));
      if (k >= 17 && k <= 32 && bus.led == 4'hF) hi++;
      if (k == 37) bus.mode = MODE_OFF;
      if (k == 70) bus.mode = MODE_BREATHE;
    end
    chk("steady_hi_cycles", 32'(hi), 32'd8);

    // Reset in the middle of BREATHE while the LEDs are lit.
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_mid_led", 32'(bus.led), 32'h0);
      chk("rst_mid_tick", 32'(bus.step_tick), 32'h0);
    end
    chk("rst_mid_pwm", 32'(dut.pwm_q), 32'h0);
    chk("rst_mid_div", 32'(dut.div_q), 32'h0);
    chk("rst_mid_phase", 32'(dut.phase_q), 32'h0);

    // BREATHE without stagger.
    rst_n        = 1'b1;
    bus.mode     = MODE_BREATHE;
    bus.phase_en = 1'b0;
    t            = 0;
    run_breathe(150);

    // Pause for 20 cycles and confirm the state is frozen.
    bus.en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("pause_led", 32'(bus.led), 32'h0);
      chk("pause_tick", 32'(bus.step_tick), 32'h0);
    end
    chk("pause_pwm", 32'(dut.pwm_q), 32'd6);
    chk("pause_phase", 32'(dut.phase_q), 32'd18);
    chk("pause_div", 32'(dut.div_q), 32'd0);
    bus.en = 1'b1;
    run_breathe(191);

    // Stagger on; state 192 is phase 0.
    bus.phase_en = 1'b1;
    cyc();
    t++;
    chk("stagger_duty", 32'(duties()), 32'h7F80);
    bus.mode = MODE_BLINK;
    cyc();
    t++;
    chk("stagger_led", 32'(bus.led), 32'hE);

    // BLINK with stagger: phase 16 at state 240, phase 0 at state 288.
    while (t < 241) begin
      cyc();
      t++;
    end
    chk("blink_half", 32'(bus.led), 32'hC);
    while (t < 289) begin
      cyc();
      t++;
    end
    for (int k = 0; k < 3; k++) begin
      chk("blink_phase0", 32'(bus.led), 32'h3);
      cyc();
      t++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
